// File: rtl/qpp_addr_gen.sv
// LTE QPP interleaver address generator for one lane: emits pi(8n+o) for n = 0..K/8-1.
// Latency: start -> first address one cycle later; one address per cycle while addr_ready is high.
// Backpressure: addr, n and last hold while addr_valid & ~addr_ready; count_enable follows the handshake.
module qpp_addr_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        block_size,
    input  logic [2:0]  offset,
    output logic [12:0] addr,
    output logic        addr_valid,
    input  logic        addr_ready,
    output logic        last,
    output logic        count_enable,
    output logic        busy
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_size, w_size_nxt;
    logic [2:0]  r_off, w_off_nxt;
    logic [12:0] r_addr, w_addr_nxt;
    logic [9:0]  r_n, w_n_nxt;

    logic [12:0] w_seed;
    logic [12:0] w_delta;
    logic [12:0] w_k;
    logic [9:0]  w_term;
    logic [13:0] w_sum;
    logic [12:0] w_wrap;
    logic [12:0] w_step;
    logic        w_hs;
    logic        w_at_term;

    // pi(o) for the offset/size presented alongside start
    always_comb begin
        w_seed = 13'd0;
        case ({block_size, offset})
            4'b0_000: w_seed = 13'd0;
            4'b0_001: w_seed = 13'd83;
            4'b0_010: w_seed = 13'd298;
            4'b0_011: w_seed = 13'd645;
            4'b0_100: w_seed = 13'd68;
            4'b0_101: w_seed = 13'd679;
            4'b0_110: w_seed = 13'd366;
            4'b0_111: w_seed = 13'd185;
            4'b1_000: w_seed = 13'd0;
            4'b1_001: w_seed = 13'd743;
            4'b1_010: w_seed = 13'd2446;
            4'b1_011: w_seed = 13'd5109;
            4'b1_100: w_seed = 13'd2588;
            4'b1_101: w_seed = 13'd1027;
            4'b1_110: w_seed = 13'd426;
            4'b1_111: w_seed = 13'd785;
            default:  w_seed = 13'd0;
        endcase
    end

    // Stride-8 increment depends only on the latched size and offset mod 4
    always_comb begin
        w_delta = 13'd136;
        if (r_size) begin
            case (r_off[1:0])
                2'd0:    w_delta = 13'd2104;
                2'd1:    w_delta = 13'd3640;
                2'd2:    w_delta = 13'd5176;
                default: w_delta = 13'd568;
            endcase
        end
    end

    assign w_k       = r_size ? 13'd6144 : 13'd1056;
    assign w_term    = r_size ? 10'd767  : 10'd131;
    assign w_sum     = {1'b0, r_addr} + {1'b0, w_delta};
    // Result is < K < 8192, so the low 13 bits of the difference are exact
    assign w_wrap    = w_sum[12:0] - w_k;
    assign w_step    = (w_sum >= {1'b0, w_k}) ? w_wrap : w_sum[12:0];
    assign w_hs      = (r_state == S_RUN) && addr_ready;
    assign w_at_term = (r_n == w_term);

    always_comb begin
        w_state_nxt = r_state;
        w_size_nxt  = r_size;
        w_off_nxt   = r_off;
        w_addr_nxt  = r_addr;
        w_n_nxt     = r_n;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_size_nxt  = block_size;
                    w_off_nxt   = offset;
                    w_addr_nxt  = w_seed;
                    w_n_nxt     = 10'd0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_hs) begin
                    if (w_at_term) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_addr_nxt = w_step;
                        w_n_nxt    = r_n + 10'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_size  <= 1'b0;
            r_off   <= 3'd0;
            r_addr  <= 13'd0;
            r_n     <= 10'd0;
        end else begin
            r_state <= w_state_nxt;
            r_size  <= w_size_nxt;
            r_off   <= w_off_nxt;
            r_addr  <= w_addr_nxt;
            r_n     <= w_n_nxt;
        end
    end

    assign addr         = r_addr;
    assign addr_valid   = (r_state == S_RUN);
    assign busy         = (r_state == S_RUN);
    assign last         = (r_state == S_RUN) && w_at_term;
    assign count_enable = addr_valid && addr_ready;

endmodule

// File: tb/tb_qpp_addr_gen.sv
// Bench for qpp_addr_gen: compares every address against the direct QPP formula.
module tb_qpp_addr_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        block_size = 1'b0;
    logic [2:0]  offset = 3'd0;
    logic        addr_ready = 1'b0;
    logic [12:0] addr;
    logic        addr_valid;
    logic        last;
    logic        count_enable;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int seen [0:6143];

    qpp_addr_gen dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .block_size   (block_size),
        .offset       (offset),
        .addr         (addr),
        .addr_valid   (addr_valid),
        .addr_ready   (addr_ready),
        .last         (last),
        .count_enable (count_enable),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic int model(input bit sz, input int o, input int n);
        longint k  = sz ? 6144 : 1056;
        longint f1 = sz ? 263 : 17;
        longint f2 = sz ? 480 : 66;
        longint i  = 8 * n + o;
        return int'((f1 * i + f2 * i * i) % k);
    endfunction

    // Runs one block from a start pulse to the cycle after its final handshake.
    task automatic run_block(input bit sz, input int o, input bit rnd, input int poke_at,
                             input bit start_on_last, output int ce_cnt, output int busy_cyc,
                             output int first_addr, output int last_addr);
        int          nblk = sz ? 768 : 132;
        int          cnt  = 0;
        int          cyc  = 0;
        bit          rdy;
        logic [12:0] ea;
        ce_cnt = 0; busy_cyc = 0; first_addr = -1; last_addr = -1;
        block_size = sz; offset = 3'(o); start = 1'b1; addr_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (cnt < nblk && cyc < 8 * nblk + 50) begin
            ea = 13'(model(sz, o, cnt));
            checks++;
            if (addr_valid !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL run_valid sz=%0d o=%0d n=%0d: valid=%b busy=%b expected 1 1", sz, o, cnt, addr_valid, busy);
            end
            checks++;
            if (addr !== ea) begin
                errors++;
                $display("FAIL run_addr sz=%0d o=%0d n=%0d: got %0d expected %0d", sz, o, cnt, addr, ea);
            end
            checks++;
            if (last !== (cnt == nblk - 1)) begin
                errors++;
                $display("FAIL run_last sz=%0d o=%0d n=%0d: got %b expected %b", sz, o, cnt, last, cnt == nblk - 1);
            end
            if (busy === 1'b1) busy_cyc++;
            rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            addr_ready = rdy;
            if (poke_at == cnt) begin
                start = 1'b1; block_size = ~sz; offset = 3'(o + 3);
            end else begin
                start = start_on_last && (cnt == nblk - 1) && rdy;
            end
            #1;
            checks++;
            if (count_enable !== rdy) begin
                errors++;
                $display("FAIL run_ce n=%0d: got %b expected %b", cnt, count_enable, rdy);
            end
            if (count_enable === 1'b1) ce_cnt++;
            if (rdy) begin
                if (cnt == 0) first_addr = int'(addr);
                if (cnt == nblk - 1) last_addr = int'(addr);
                if (int'(addr) < 6144) seen[int'(addr)]++;
                cnt++;
            end
            cyc++;
            @(negedge clk);
        end
        if (cnt < nblk) begin
            errors++;
            $display("FAIL run_timeout sz=%0d o=%0d: got %0d handshakes expected %0d", sz, o, cnt, nblk);
        end
        start = 1'b0; addr_ready = 1'b0;
        checks++;
        if (addr_valid !== 1'b0 || busy !== 1'b0 || last !== 1'b0) begin
            errors++;
            $display("FAIL run_end sz=%0d o=%0d: valid=%b busy=%b last=%b expected 0 0 0", sz, o, addr_valid, busy, last);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; addr_ready = 1'b1;
        #1;
        checks++;
        if ({addr, addr_valid, last, busy, count_enable} !== 17'd0) begin
            errors++;
            $display("FAIL reset_vals: addr=%0d valid=%b last=%b busy=%b ce=%b expected all 0", addr, addr_valid, last, busy, count_enable);
        end
        @(negedge clk); reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (addr_valid !== 1'b0 || count_enable !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: valid=%b ce=%b busy=%b expected 0 0 0", addr_valid, count_enable, busy);
        end
        addr_ready = 1'b0;
    endtask

    task automatic test_k1056_o0();
        int ce, bc, fa, la;
        run_block(1'b0, 0, 1'b0, -1, 1'b0, ce, bc, fa, la);
        checks++;
        if (la != 920) begin
            errors++;
            $display("FAIL k1056_last_addr: got %0d expected 920", la);
        end
        checks++;
        if (bc != 132 || ce != 132) begin
            errors++;
            $display("FAIL k1056_cycles: busy=%0d ce=%0d expected 132 132", bc, ce);
        end
    endtask

    task automatic test_k6144_o1();
        int ce, bc, fa, la;
        run_block(1'b1, 1, 1'b0, -1, 1'b0, ce, bc, fa, la);
        checks++;
        if (fa != 743 || bc != 768) begin
            errors++;
            $display("FAIL k6144_o1: first=%0d busy=%0d expected 743 768", fa, bc);
        end
    endtask

    task automatic test_stall_o3();
        int ce, bc, fa, la;
        run_block(1'b1, 3, 1'b1, -1, 1'b0, ce, bc, fa, la);
        checks++;
        if (ce != 768) begin
            errors++;
            $display("FAIL stall_ce_count: got %0d expected 768", ce);
        end
    endtask

    task automatic test_all_offsets();
        int ce, bc, fa, la, bad;
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 6144; a++) seen[a] = 0;
            for (int o = 0; o < 8; o++) begin
                run_block(s[0], o, 1'b0, -1, 1'b0, ce, bc, fa, la);
                checks++;
                if (fa != model(s[0], o, 0)) begin
                    errors++;
                    $display("FAIL seed sz=%0d o=%0d: got %0d expected %0d", s, o, fa, model(s[0], o, 0));
                end
            end
            bad = 0;
            for (int a = 0; a < 6144; a++) begin
                if (a < (s == 1 ? 6144 : 1056)) begin
                    if (seen[a] != 1) bad++;
                end else if (seen[a] != 0) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL coverage sz=%0d: got %0d bad addresses expected 0", s, bad);
            end
        end
    endtask

    task automatic test_mid_start();
        int ce, bc, fa, la;
        run_block(1'b0, 4, 1'b0, 50, 1'b0, ce, bc, fa, la);
        checks++;
        if (bc != 132) begin
            errors++;
            $display("FAIL mid_start_len: got %0d expected 132", bc);
        end
    endtask

    task automatic test_back_to_back();
        int ce, bc, fa, la;
        run_block(1'b0, 6, 1'b0, -1, 1'b1, ce, bc, fa, la);
        run_block(1'b1, 2, 1'b0, -1, 1'b0, ce, bc, fa, la);
        checks++;
        if (fa != 2446) begin
            errors++;
            $display("FAIL back_to_back_first: got %0d expected 2446", fa);
        end
    endtask

    task automatic test_reset_mid();
        int ce, bc, fa, la;
        int cnt = 0;
        block_size = 1'b1; offset = 3'd5; start = 1'b1; addr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cnt < 300 && addr_valid === 1'b1) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (addr !== 13'(model(1'b1, 5, 300))) begin
            errors++;
            $display("FAIL pre_reset_addr: got %0d expected %0d", addr, model(1'b1, 5, 300));
        end
        reset = 1'b0;
        #1;
        checks++;
        if (addr_valid !== 1'b0 || busy !== 1'b0 || addr !== 13'd0 || last !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b busy=%b addr=%0d last=%b expected 0 0 0 0", addr_valid, busy, addr, last);
        end
        @(negedge clk); reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (addr_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: valid=%b busy=%b expected 0 0", addr_valid, busy);
        end
        addr_ready = 1'b0;
        run_block(1'b1, 5, 1'b1, -1, 1'b0, ce, bc, fa, la);
        checks++;
        if (fa != 1027) begin
            errors++;
            $display("FAIL restart_first: got %0d expected 1027", fa);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_k1056_o0();
        test_k6144_o1();
        test_stall_o3();
        test_all_offsets();
        test_mid_start();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qpp_addr_gen.md
# qpp_addr_gen

Generates the LTE quadratic-permutation-polynomial (QPP) interleaved address stream for one lane of the 8-lane interleaver, π(i) = (f1·i + f2·i²) mod K, for i = 8n + offset, n = 0 … K/8−1. It sits directly downstream of the lane's linear-index counter wrapper:
- the counter supplies the linear (write) index;
- this block supplies the matching interleaved (read) index;
- this block drives the counter's `count_enable` so the two advance in lockstep.

Output is a valid/ready stream to the interleaver memory read port.

## Interface
Parameters: none (K ∈ {1056, 6144} fixed by `block_size`).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `start` in 1: one-cycle pulse; begins a block. Ignored unless idle.
- `block_size` in 1: 0 = K 1056 (f1 17, f2 66), 1 = K 6144 (f1 263, f2 480). Sampled on accepted `start`.
- `offset` in 3: lane offset o (0–7). Sampled on accepted `start`.
- `addr` out 13: current interleaved address π(8n+o).
- `addr_valid` out 1: `addr` is valid.
- `addr_ready` in 1: consumer accepts `addr` this cycle.
- `last` out 1: high with `addr_valid` on the final address of the block (n = K/8−1).
- `count_enable` out 1: = `addr_valid & addr_ready`; drives the upstream counter's `count_enable`.
- `busy` out 1: high from accepted `start` until the final handshake.

## Operation
- Stride-8 recursion: π(i+8) − π(i) mod K is a constant Δ per (K, o), because the 128·f2 term is ≡ 0 mod K for both sizes.
  - K 1056: Δ = 136 for all o.
  - K 6144: Δ by o mod 4 = 2104, 3640, 5176, 568.
- Seed π0 = π(o):
  - K 1056, o = 0…7: 0, 83, 298, 645, 68, 679, 366, 185.
  - K 6144, o = 0…7: 0, 743, 2446, 5109, 2588, 1027, 426, 785.
- π0 and Δ are constant tables indexed by `block_size` and `offset`; no multipliers.
- Update arithmetic: s = addr + Δ (14 bits); next = s − K if s ≥ K, else s. Operands are always < K, so one conditional subtract suffices.
- Step counter `n`: 10 bits. Terminal value N−1 = 131 (K 1056) or 767 (K 6144).
- FSM:
  - IDLE: `addr_valid` = 0, `busy` = 0. On `start`: latch size and offset, `addr` ← π0, `n` ← 0, go to RUN.
  - RUN: `addr_valid` = 1.
    - Handshake with `n` < N−1: `addr` ← next, `n` ← `n`+1.
    - Handshake with `n` = N−1: go to IDLE.
    - No handshake: `addr`, `n` and `last` hold (stall).
- `last` = RUN & (`n` = N−1).
- `start` in RUN is ignored; latched size and offset are unaffected.
- `addr` holds its final value in IDLE.

## Timing
- Reset values: `addr` = 0, `addr_valid` = 0, `last` = 0, `busy` = 0, `count_enable` = 0, FSM = IDLE, `n` = 0.
- Latency: `start` at cycle t → `addr_valid` = 1 with `addr` = π0 at t+1.
- Throughput: with `addr_ready` held high, one address per cycle. A full block takes N cycles (132 or 768) and `busy` = 1 for exactly N cycles.
- `count_enable` is combinational from `addr_valid` and `addr_ready`. The counter advances on the same edge as `addr`.
- Back-to-back blocks: `start` in the cycle after the final handshake (FSM in IDLE) is accepted. Minimum gap is 1 idle cycle.
- `start` coincident with the final handshake is ignored.
- `reset` asserted mid-block: outputs drop to reset values asynchronously. After deassertion the block waits in IDLE for a fresh `start`.
- `addr_ready` high while `addr_valid` = 0 has no effect; `count_enable` stays 0.

## Test plan
- K 1056, o 0, `addr_ready` = 1: sequence 0, 136, 272, …; `addr` on n = 131 is 17816 mod 1056 = 920, with `last` = 1. 132 valid cycles, then `busy` = 0.
- K 6144, o 1, `addr_ready` = 1: first three addresses 743, 4383, 1879. `last` only on the 768th address. Compare every address against the direct π(8n+1) model.
- K 6144, o 3, random `addr_ready` stalls: each address is held stable while not ready. `count_enable` pulse count = 768. Full sequence matches the model, exercising the modular wrap for Δ 568.
- All 16 (size, offset) combinations: first address equals the π0 table value. The sequence is a permutation-consistent subset: the union over all 8 offsets covers 0…K−1 exactly once.
- `start` pulsed mid-block (K 1056, n = 50): sequence and `n` are unaffected. `start` one cycle after `last` handshake (K 1056 → K 6144, o 2) yields 2446 on the next cycle.
- `reset` low at K 6144, n = 300: `addr_valid`, `busy` and `addr` drop to 0 within the same cycle. After release, no output until `start`, and the restarted block begins again at π0.
